// File: rtl/block_ram_be_pipe_pkg.sv
// Shared constants for the byte-enable simple-dual-port RAM: collision modes,
// clear-FSM state encoding and the byte-lane helper.
package bram_pkg;

  localparam int COLL_READ_OLD      = 0;
  localparam int COLL_WRITE_THROUGH = 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int nb(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/block_ram_be_pipe_core.sv
// Bare RAM array: per-byte-lane write port and a registered read port, shaped
// so synthesis maps it onto block RAM with byte write enables.
module bram_sdp_core #(
  parameter int    ADDR_WIDTH = 13,
  parameter int    DATA_WIDTH = 32,
  parameter int    NB         = DATA_WIDTH / 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NB-1:0]         we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (we_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  // Non-blocking read of the same edge as a write yields the pre-write word.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_ram_be_pipe.sv
// Byte-enable simple-dual-port RAM with selectable read latency, defined
// same-address collision behaviour, read-valid strobe and post-reset clear.
module block_ram_be_pipe
  import bram_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 13,
  parameter int    DATA_WIDTH     = 32,
  parameter int    READ_LATENCY   = 1,
  parameter int    COLLISION_MODE = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                        clka_i,
  input  logic                        rstn_i,
  input  logic [ADDR_WIDTH-1:0]       addra_i,
  input  logic [DATA_WIDTH-1:0]       dina_i,
  input  logic [nb(DATA_WIDTH)-1:0]   wea_i,
  input  logic [ADDR_WIDTH-1:0]       addrb_i,
  input  logic                        enb_i,
  output logic [DATA_WIDTH-1:0]       doutb_o,
  output logic                        doutb_valid_o,
  output logic                        busy_o
);

  localparam int                NB    = nb(DATA_WIDTH);
  localparam int                DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH + 1)'(1);

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("block_ram_be_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("block_ram_be_pipe: READ_LATENCY must be 1 or 2");
    end
    if (COLLISION_MODE != COLL_READ_OLD && COLLISION_MODE != COLL_WRITE_THROUGH) begin : g_bad_mode
      $error("block_ram_be_pipe: COLLISION_MODE must be 0 or 1");
    end
  endgenerate

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  clearing;
  logic                  rd_acc;
  logic [NB-1:0]         core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [NB-1:0]         fwd_we_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  v1_q;

  assign clearing = (state_q == ST_CLEAR);
  assign busy_o   = clearing;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clearing) begin
      cnt_d = cnt_q + ONE;
      if (cnt_q == LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clka_i) begin
    if (!rstn_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer owns the write port while busy; reset never writes the array.
  assign core_we    = !rstn_i ? '0 : (clearing ? '1 : wea_i);
  assign core_waddr = clearing ? cnt_q[ADDR_WIDTH-1:0] : addra_i;
  assign core_wdata = clearing ? '0 : dina_i;
  assign rd_acc     = rstn_i && !clearing && enb_i;

  bram_sdp_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NB         (NB),
    .INIT_FILE  (INIT_FILE)
  ) u_core (
    .clk_i   (clka_i),
    .rstn_i  (rstn_i),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .re_i    (rd_acc),
    .raddr_i (addrb_i),
    .rdata_o (core_rdata)
  );

  // Forward lanes hold the colliding write alongside the read they overlay.
  always_ff @(posedge clka_i) begin
    if (!rstn_i) begin
      fwd_we_q   <= '0;
      fwd_data_q <= '0;
    end else if (rd_acc) begin
      fwd_we_q   <= (COLLISION_MODE == COLL_WRITE_THROUGH && addra_i == addrb_i) ? wea_i : '0;
      fwd_data_q <= dina_i;
    end
  end

  always_comb begin
    merged = core_rdata;
    for (int i = 0; i < NB; i++) begin
      if (fwd_we_q[i]) merged[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  always_ff @(posedge clka_i) begin
    if (!rstn_i) v1_q <= 1'b0;
    else         v1_q <= rd_acc;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clka_i) begin
        if (!rstn_i) begin
          v2_q   <= 1'b0;
          dout_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) dout_q <= merged;
        end
      end

      assign doutb_o       = dout_q;
      assign doutb_valid_o = v2_q;
    end else begin : g_lat1
      assign doutb_o       = merged;
      assign doutb_valid_o = v1_q;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_be_pipe.sv
// Drives four RAM configurations (latency x collision mode x clear) with one
// shared stimulus stream and compares each against an array/slot reference model.
module tb_block_ram_be_pipe;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NBL   = 4;
  localparam int DEPTH = 16;
  localparam int NI    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dina;
  logic [NBL-1:0] wea;
  logic          enb;

  logic [DW-1:0] dout [NI];
  logic          vld  [NI];
  logic          bsy  [NI];

  int checks   = 0;
  int failures = 0;

  function automatic int lat_of(int k);  return 1 + (k % 2); endfunction
  function automatic int mode_of(int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int clr_of(int k);  return k / 2; endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      block_ram_be_pipe #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .READ_LATENCY   (1 + (gi % 2)),
        .COLLISION_MODE ((gi == 1 || gi == 2) ? 1 : 0),
        .CLEAR_ON_RESET (gi / 2),
        .INIT_FILE      ("")
      ) u_dut (
        .clka_i        (clk),
        .rstn_i        (rstn),
        .addra_i       (addra),
        .dina_i        (dina),
        .wea_i         (wea),
        .addrb_i       (addrb),
        .enb_i         (enb),
        .doutb_o       (dout[gi]),
        .doutb_valid_o (vld[gi]),
        .busy_o        (bsy[gi])
      );
    end
  endgenerate

  // Reference model: memory image, remaining clear words, and a result slot
  // per edge number (a read accepted at edge e is seen after edge e+lat-1).
  logic [DW-1:0] m_mem    [NI][DEPTH];
  int            m_busy   [NI];
  logic [DW-1:0] m_slot_d [NI][4];
  bit            m_slot_v [NI][4];
  logic [DW-1:0] e_dout   [NI];
  bit            e_vld    [NI];
  int            edge_n = 0;

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      logic [DW-1:0] rd;
      int slot;
      if (!rstn) begin
        m_busy[k] = (clr_of(k) != 0) ? DEPTH : 0;
        for (int s = 0; s < 4; s++) m_slot_v[k][s] = 1'b0;
        e_dout[k] = '0;
        e_vld[k]  = 1'b0;
      end else begin
        if (m_busy[k] == 0) begin
          if (enb) begin
            rd = m_mem[k][addrb];
            if (mode_of(k) == 1 && addra == addrb) begin
              for (int b = 0; b < NBL; b++)
                if (wea[b]) rd[8*b +: 8] = dina[8*b +: 8];
            end
            slot = (edge_n + lat_of(k) - 1) % 4;
            m_slot_v[k][slot] = 1'b1;
            m_slot_d[k][slot] = rd;
          end
          for (int b = 0; b < NBL; b++)
            if (wea[b]) m_mem[k][addra][8*b +: 8] = dina[8*b +: 8];
        end else begin
          m_mem[k][DEPTH - m_busy[k]] = '0;
          m_busy[k] = m_busy[k] - 1;
        end
        slot = edge_n % 4;
        e_vld[k] = m_slot_v[k][slot];
        if (e_vld[k]) begin
          e_dout[k] = m_slot_d[k][slot];
          m_slot_v[k][slot] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NBL-1:0] we, input logic [AW-1:0] ra, input bit re);
    rstn  = r;
    addra = wa;
    dina  = wd;
    wea   = we;
    addrb = ra;
    enb   = re;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.busy", k),  {31'b0, bsy[k]}, {31'b0, m_busy[k] != 0});
      chk($sformatf("u%0d.valid", k), {31'b0, vld[k]}, {31'b0, e_vld[k]});
      chk($sformatf("u%0d.doutb", k), dout[k], e_dout[k]);
    end
    $display("edge=%0d rstn=%0b wa=%0d wd=%h we=%h ra=%0d re=%0b valid=%0b%0b%0b%0b busy=%0b%0b",
             edge_n, r, wa, wd, we, ra, re, vld[0], vld[1], vld[2], vld[3], bsy[2], bsy[3]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic reads_all();
    for (int a = 0; a < DEPTH; a++) step(1'b1, '0, '0, '0, AW'(a), 1'b1);
    idle(2);
  endtask

  task automatic fill(input logic [DW-1:0] pattern, input bit use_addr);
    for (int a = 0; a < DEPTH; a++)
      step(1'b1, AW'(a), use_addr ? DW'(a) : pattern, 4'hF, '0, 1'b0);
  endtask

  initial begin
    // Power-up reset, then let the clearing configurations finish.
    step(1'b0, '0, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    idle(16);
    chk("clr_done_u2", {31'b0, bsy[2]}, 32'd0);

    // Preload value=address, then stream all 16 words back-to-back.
    fill('0, 1'b1);
    reads_all();

    // Byte enables.
    step(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, '0, 1'b0);
    step(1'b1, 4'd3, 32'h11223344, 4'b0101, '0, 1'b0);
    step(1'b1, '0, '0, '0, 4'd3, 1'b1);
    chk("be_lat1_data", dout[0], 32'hAA22CC44);
    chk("be_lat1_valid", {31'b0, vld[0]}, 32'd1);
    chk("be_lat2_early", {31'b0, vld[1]}, 32'd0);
    idle(1);
    chk("be_lat2_data", dout[1], 32'hAA22CC44);
    chk("be_lat2_valid", {31'b0, vld[1]}, 32'd1);
    idle(1);

    // Same-address collision.
    step(1'b1, 4'd5, 32'h0, 4'hF, '0, 1'b0);
    step(1'b1, 4'd5, 32'hDEADBEEF, 4'b0011, 4'd5, 1'b1);
    chk("coll_old_lat1", dout[0], 32'h00000000);
    chk("coll_wt_lat1", dout[2], 32'h0000BEEF);
    step(1'b1, '0, '0, '0, 4'd5, 1'b1);
    chk("coll_next_lat1", dout[0], 32'h0000BEEF);
    chk("coll_wt_lat2", dout[1], 32'h0000BEEF);
    chk("coll_old_lat2", dout[3], 32'h00000000);
    idle(1);
    chk("coll_next_lat2_wt", dout[1], 32'h0000BEEF);
    chk("coll_next_lat2_old", dout[3], 32'h0000BEEF);
    idle(1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) != 0, AW'($urandom), DW'($urandom), NBL'($urandom),
           AW'($urandom), 1'($urandom));
    idle(20);
    reads_all();

    // Clear after reset: accesses while busy are ignored.
    fill(32'hFFFFFFFF, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    step(1'b1, 4'd7, 32'h12345678, 4'hF, 4'd7, 1'b1);
    chk("clr_busy_write_ignored", {31'b0, vld[2]}, 32'd0);
    idle(14);
    chk("clr_busy_edge15", {31'b0, bsy[3]}, 32'd1);
    idle(1);
    chk("clr_busy_edge16", {31'b0, bsy[3]}, 32'd0);
    reads_all();

    // Reset in the middle of a clear restarts it.
    fill(32'hFFFFFFFF, 1'b0);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    idle(7);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    idle(15);
    chk("midclr_still_busy", {31'b0, bsy[2]}, 32'd1);
    idle(1);
    chk("midclr_done", {31'b0, bsy[2]}, 32'd0);
    reads_all();

    // Reset in the middle of a read drops it.
    fill(32'hFFFFFFFF, 1'b0);
    step(1'b1, '0, '0, '0, 4'd2, 1'b1);
    step(1'b0, '0, '0, '0, '0, 1'b0);
    chk("midrd_dout", dout[1], 32'd0);
    chk("midrd_valid", {31'b0, vld[1]}, 32'd0);
    idle(1);
    chk("midrd_no_late_valid", {31'b0, vld[1]}, 32'd0);
    idle(17);
    reads_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_ram_be_pipe.md
Name: block_ram_be_pipe

Overview:
- Next-generation simple-dual-port block RAM for the SoC code/data memories.
- Port A writes with per-byte enables; port B reads. Both ports share one clock.
- New compared with the current RAM:
  - data width is a parameter (any multiple of 8); depth and init file are parameters;
  - read latency is selectable (1 or 2);
  - same-address collision behaviour is defined and selectable;
  - a read-valid strobe is provided;
  - an optional post-reset zero-clear sequencer with a busy flag.
- Sits between the bus interconnect / DMA write path and the core fetch/load path.

Parameters:
- ADDR_WIDTH, 13, word address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- READ_LATENCY, 1, cycles from accepted read (enb=1) to doutb_valid; legal values 1 or 2.
- COLLISION_MODE, 0, behaviour when a write and a read hit the same address in the same cycle:
  - 0 = READ_OLD;
  - 1 = WRITE_THROUGH (per-byte forward).
- CLEAR_ON_RESET, 0, 1 = zero every word after reset release.
- INIT_FILE, "", hex file loaded at elaboration; "" = no load.

Ports:
- clka  in  1  clock, rising-edge.
- rstn  in  1  synchronous, active-low reset.
- addra  in  ADDR_WIDTH  write word address.
- dina  in  DATA_WIDTH  write data.
- wea  in  NB  byte write enables; bit i covers dina[8i+7:8i].
- addrb  in  ADDR_WIDTH  read word address.
- enb  in  1  read request; one read accepted per cycle.
- doutb  out  DATA_WIDTH  read data.
- doutb_valid  out  1  one-cycle strobe: doutb carries data for an accepted read.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (rstn=0 at a clka edge):
  - doutb=0, doutb_valid=0, all internal pipeline valids cleared;
  - busy=CLEAR_ON_RESET;
  - FSM enters CLEAR if CLEAR_ON_RESET, otherwise READY; clear counter set to 0;
  - array contents are not altered by reset itself.
- Write: at each edge in READY, mem[addra] byte i <= dina byte i for every wea[i]=1. Unenabled bytes are unchanged. wea=0 means no write.
- Read: an edge in READY with enb=1 accepts the read.
  - READY_LATENCY 1: doutb and doutb_valid=1 appear after the next edge.
  - READ_LATENCY 2: they appear one edge later; the extra stage is an output register.
  - Back-to-back reads give one valid per cycle, in order.
  - doutb holds its last value while doutb_valid=0.
- Collision (enb=1, wea≠0, addra==addrb, same edge):
  - READ_OLD: doutb returns the pre-write word.
  - WRITE_THROUGH: for each byte with wea[i]=1, doutb returns dina byte i; other bytes return the stored value.
  - Forwarding is done from a registered copy of dina/wea/hit. The array itself is never read-after-write inside a cycle.
- Write on cycle N, read of the same address on cycle N+1: always returns the new data, in both modes.
- FSM CLEAR:
  - Writes zero, all bytes, to address cnt on each edge; cnt increments.
  - After writing DEPTH-1, goes to READY; busy falls on that same edge.
  - busy is therefore high for exactly DEPTH edges after the first edge with rstn=1.
  - While busy: wea and enb are ignored; no doutb_valid is produced.
- FSM READY: normal operation; stays there until rstn=0.
- Reset mid-clear: counter restarts at 0; the full clear reruns.
- Reset mid-read: the in-flight read is dropped; no valid strobe follows.
- Width rules:
  - addresses wrap naturally (no out-of-range);
  - the counter is ADDR_WIDTH+1 bits so the end test has no wrap ambiguity.
- CLEAR_ON_RESET=1 overrides INIT_FILE contents (intended for data RAMs only).
- Illegal parameter values (DATA_WIDTH%8≠0, READ_LATENCY∉{1,2}, COLLISION_MODE∉{0,1}) must be rejected at elaboration by an assertion.

Decomposition:
- Shared package bram_pkg:
  - localparams COLL_READ_OLD=0 and COLL_WRITE_THROUGH=1;
  - FSM state encoding ST_CLEAR and ST_READY;
  - function nb(DATA_WIDTH) returning the byte-lane count.
- Sub-module bram_sdp_core:
  - contains only the array, the per-byte-lane write and the registered read (plus INIT_FILE load);
  - kept minimal so synthesis infers block RAM with byte-write enables.
- Top level holds:
  - the clear FSM and its mux onto the core's write port;
  - the collision compare/forward register;
  - the optional output stage;
  - the valid pipeline.

Test Plan:
All scenarios use ADDR_WIDTH=4 and DATA_WIDTH=32 unless stated.
- Byte enables: write addr 3 dina=0xAABBCCDD wea=4'hF, then write addr 3 dina=0x11223344 wea=4'b0101; read addr 3 -> doutb=0xAA22CC44, with doutb_valid exactly 1 cycle (LAT=1) or 2 cycles (LAT=2) after enb.
- Collision with addr 5 holding 0x0 and a same-cycle write 0xDEADBEEF wea=4'b0011 plus read of addr 5:
  - MODE 0 -> doutb=0x00000000;
  - MODE 1 -> doutb=0x0000BEEF;
  - a following read -> 0x0000BEEF in both modes.
- Streaming: enb=1 for 16 cycles, addr 0..15 preloaded with value=addr -> 16 consecutive valids carrying 0..15 in order; no gaps for either latency.
- Clear: CLEAR_ON_RESET=1, preload all words 0xFFFFFFFF, pulse rstn=0 for 2 cycles ->
  - busy=1 for exactly 16 edges;
  - a write and a read issued while busy are ignored, with no valid;
  - reading all 16 words afterwards -> all 0.
- Reset mid-clear: assert rstn=0 at clear count 7 for 1 cycle -> busy stays high for a further 16 edges after release; all words end at 0.
- Reset mid-read: with LAT=2, assert enb at addr 2 and then rstn=0 on the next edge -> doutb=0 and doutb_valid never pulses for that read.
